// File: rtl/epu_pkg.sv
// Shared EPU definitions: layer ids, per-layer row lengths, the activation-SRAM
// write entry and the ofmap writer state encoding.
package epu_pkg;

  localparam logic [2:0] LAYER_CONV0 = 3'd0;
  localparam logic [2:0] LAYER_CONV1 = 3'd1;
  localparam logic [2:0] LAYER_CONV2 = 3'd2;
  localparam logic [2:0] LAYER_CONV3 = 3'd3;
  localparam logic [2:0] LAYER_FC0   = 3'd5;
  localparam logic [2:0] LAYER_FC1   = 3'd6;

  localparam logic [5:0] ROW_LEN_CONV0 = 6'd48;
  localparam logic [5:0] ROW_LEN_CONV1 = 6'd22;
  localparam logic [5:0] ROW_LEN_CONV2 = 6'd9;
  localparam logic [5:0] ROW_LEN_CONV3 = 6'd2;
  localparam logic [5:0] ROW_LEN_FC    = 6'd1;

  // Wide enough for any byte-address width up to 32 bits.
  localparam int unsigned WR_ADDR_W = 30;

  typedef struct packed {
    logic [WR_ADDR_W-1:0] addr;
    logic [31:0]          data;
    logic [3:0]           strb;
  } wr_entry_t;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StDrain,
    StDone
  } wr_state_e;

  function automatic logic [5:0] row_len(input logic [2:0] layer);
    case (layer)
      LAYER_CONV0:          return ROW_LEN_CONV0;
      LAYER_CONV1:          return ROW_LEN_CONV1;
      LAYER_CONV2:          return ROW_LEN_CONV2;
      LAYER_CONV3:          return ROW_LEN_CONV3;
      LAYER_FC0, LAYER_FC1: return ROW_LEN_FC;
      default:              return 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/word_fifo.sv
// Synchronous FIFO of SRAM write entries with a registered head copy, so the
// write port is driven straight from flops.
module word_fifo
  import epu_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  wr_entry_t push_data,
  input  logic      pop,
  output wr_entry_t head,
  output logic      full,
  output logic      empty,
  output logic      last
);

  localparam int unsigned PtrW = $clog2(Depth);

  wr_entry_t       mem_q [Depth];
  wr_entry_t       head_q;
  logic [PtrW-1:0] wr_q, rd_q, rd_nxt;
  logic [PtrW:0]   cnt_q;
  logic            push_ok, pop_ok;

  assign full    = (cnt_q == (PtrW+1)'(Depth));
  assign empty   = (cnt_q == '0);
  assign last    = (cnt_q == (PtrW+1)'(1));
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_nxt  = rd_q + 1'b1;
  assign head    = head_q;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      if (push_ok) begin
        wr_q <= wr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_q <= rd_nxt;
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      // Head follows the oldest entry; a push into an (emptying) FIFO bypasses storage.
      if (push_ok && (empty || (pop_ok && last))) begin
        head_q <= push_data;
      end else if (pop_ok && !last) begin
        head_q <= mem_q[rd_nxt];
      end
    end
  end

endmodule

// File: rtl/ofmap_writer.sv
// Packs the requantized byte stream of one output row into 32-bit little-endian
// words and writes them to the activation SRAM through a small word FIFO.
module ofmap_writer
  import epu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        layer,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              data_valid,
  input  logic [7:0]        data_in,
  output logic              mem_req,
  input  logic              mem_ready,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  wr_state_e         state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [5:0]        cnt_q, cnt_d, len_q, len_d;
  logic [31:0]       pack_data_q, pack_data_d;
  logic [3:0]        pack_strb_q, pack_strb_d;
  logic              overflow_q, overflow_d;

  logic [5:0]  start_len;
  logic        last_byte;
  logic [31:0] lane_data;
  logic [3:0]  lane_strb;
  logic        push, pop;
  wr_entry_t   push_entry, head;
  logic        fifo_full, fifo_empty, fifo_last;
  logic        unused_head_addr;

  assign start_len = row_len(layer);
  assign last_byte = (cnt_q == len_q - 6'd1);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    pack_data_d = pack_data_q;
    pack_strb_d = pack_strb_q;
    overflow_d  = overflow_q;
    lane_data   = pack_data_q;
    lane_strb   = pack_strb_q;
    push        = 1'b0;
    push_entry  = '0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          ptr_d       = base_addr;
          cnt_d       = '0;
          len_d       = start_len;
          pack_data_d = '0;
          pack_strb_d = '0;
          overflow_d  = 1'b0;
          state_d     = (start_len == 6'd0) ? StDone : StCollect;
        end
      end
      StCollect: begin
        if (data_valid) begin
          lane_data[{ptr_q[1:0], 3'b000} +: 8] = data_in;
          lane_strb[ptr_q[1:0]]                = 1'b1;
          pack_data_d = lane_data;
          pack_strb_d = lane_strb;
          ptr_d       = ptr_q + 1'b1;
          cnt_d       = cnt_q + 6'd1;
          if (ptr_q[1:0] == 2'd3 || last_byte) begin
            push            = 1'b1;
            push_entry.addr = WR_ADDR_W'(ptr_q[ADDR_W-1:2]);
            push_entry.data = lane_data;
            push_entry.strb = lane_strb;
            pack_data_d     = '0;
            pack_strb_d     = '0;
            // A full FIFO drops the word; the row still runs to completion.
            if (fifo_full) begin
              overflow_d = 1'b1;
            end
          end
          if (last_byte) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        // Leave as the final word is accepted so done lands in the next cycle.
        if (fifo_empty || (fifo_last && pop)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      pack_data_q <= '0;
      pack_strb_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      pack_data_q <= pack_data_d;
      pack_strb_q <= pack_strb_d;
      overflow_q  <= overflow_d;
    end
  end

  word_fifo #(
    .Depth(FIFO_DEPTH)
  ) u_word_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .last     (fifo_last)
  );

  assign mem_req          = !fifo_empty;
  assign pop              = mem_req && mem_ready;
  assign mem_addr         = head.addr[ADDR_W-3:0];
  assign mem_wdata        = head.data;
  assign mem_wstrb        = head.strb;
  assign unused_head_addr = ^head.addr;

  assign busy     = (state_q != StIdle) || start;
  assign done     = (state_q == StDone);
  assign overflow = overflow_q;

endmodule
